// File: rtl/stopwatch_dp_if.sv
//------------------------------------------------------------------------------
// Module   : stopwatch_dp_if
// Purpose  : Control and display bundle of the stopwatch datapath.
//            master : the controller side (drives the mode levels, reads time)
//            slave  : the stopwatch itself
// Signals  : i_clear, i_runstop, i_count_down  - mode request levels
//            o_msec[6:0], o_sec[5:0], o_min[5:0], o_hour[4:0] - time fields
//            o_zero                             - count-down reached zero
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface stopwatch_dp_if;
  logic       i_clear;
  logic       i_runstop;
  logic       i_count_down;
  logic [6:0] o_msec;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hour;
  logic       o_zero;

  modport master (
    output i_clear, i_runstop, i_count_down,
    input  o_msec, o_sec, o_min, o_hour, o_zero
  );

  modport slave (
    input  i_clear, i_runstop, i_count_down,
    output o_msec, o_sec, o_min, o_hour, o_zero
  );
endinterface

`default_nettype wire

// File: rtl/stopwatch_dp.sv
//------------------------------------------------------------------------------
// Module   : stopwatch_dp
// Purpose  : Up/down stopwatch, hh:mm:ss.cc, driven by a divided time base.
// Ports    : clk  - system clock, rising edge
//            rst  - asynchronous active-high reset
//            sw   - stopwatch_dp_if.slave (mode levels in, time fields and
//                   zero pulse out)
// Params   : CLK_FREQ - clock frequency in Hz
//            TICK_HZ  - time-base rate in Hz (CLK_FREQ/TICK_HZ >= 2)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module stopwatch_dp #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int TICK_HZ  = 100
) (
  input  wire logic     clk,
  input  wire logic     rst,
  stopwatch_dp_if.slave sw
);

  localparam int DIV   = CLK_FREQ / TICK_HZ;
  localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV - 1);

  localparam logic [1:0] MODE_HOLD  = 2'd0;
  localparam logic [1:0] MODE_UP    = 2'd1;
  localparam logic [1:0] MODE_DOWN  = 2'd2;
  localparam logic [1:0] MODE_CLEAR = 2'd3;

  logic [DIV_W-1:0] div_q, div_d;
  logic [6:0]       msec_q, msec_d;
  logic [5:0]       sec_q, sec_d;
  logic [5:0]       min_q, min_d;
  logic [4:0]       hour_q, hour_d;
  logic             zero_q, zero_d;

  logic [1:0] mode;
  logic       at_zero;
  logic       at_one;
  logic       tick;

  always_comb begin
    mode = MODE_HOLD;
    if (sw.i_clear)           mode = MODE_CLEAR;
    else if (sw.i_count_down) mode = MODE_DOWN;
    else if (sw.i_runstop)    mode = MODE_UP;
  end

  assign at_zero = (hour_q == 5'd0) && (min_q == 6'd0) && (sec_q == 6'd0) &&
                   (msec_q == 7'd0);
  assign at_one  = (hour_q == 5'd0) && (min_q == 6'd0) && (sec_q == 6'd0) &&
                   (msec_q == 7'd1);

  // A count-down parked at zero freezes the divider at 0, so a later mode
  // change starts a full period rather than a stale partial one.
  assign tick = ((mode == MODE_UP) || ((mode == MODE_DOWN) && !at_zero)) &&
                (div_q == DIV_MAX);

  always_comb begin
    div_d  = div_q;
    msec_d = msec_q;
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    zero_d = 1'b0;

    case (mode)
      MODE_CLEAR: begin
        div_d  = '0;
        msec_d = '0;
        sec_d  = '0;
        min_d  = '0;
        hour_d = '0;
      end
      MODE_UP, MODE_DOWN: begin
        if ((mode == MODE_DOWN) && at_zero) div_d = '0;
        else if (div_q == DIV_MAX)          div_d = '0;
        else                                div_d = div_q + 1'b1;
      end
      default: ;
    endcase

    // Whole cascade resolved combinationally so every field lands together.
    if (tick && (mode == MODE_UP)) begin
      if (msec_q == 7'd99) begin
        msec_d = '0;
        if (sec_q == 6'd59) begin
          sec_d = '0;
          if (min_q == 6'd59) begin
            min_d  = '0;
            hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        msec_d = msec_q + 7'd1;
      end
    end else if (tick && (mode == MODE_DOWN)) begin
      // tick is suppressed at zero, so a borrow out of the hours never occurs
      zero_d = at_one;
      if (msec_q == 7'd0) begin
        msec_d = 7'd99;
        if (sec_q == 6'd0) begin
          sec_d = 6'd59;
          if (min_q == 6'd0) begin
            min_d  = 6'd59;
            hour_d = hour_q - 5'd1;
          end else begin
            min_d = min_q - 6'd1;
          end
        end else begin
          sec_d = sec_q - 6'd1;
        end
      end else begin
        msec_d = msec_q - 7'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      msec_q <= '0;
      sec_q  <= '0;
      min_q  <= '0;
      hour_q <= '0;
      zero_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      msec_q <= msec_d;
      sec_q  <= sec_d;
      min_q  <= min_d;
      hour_q <= hour_d;
      zero_q <= zero_d;
    end
  end

  assign sw.o_msec = msec_q;
  assign sw.o_sec  = sec_q;
  assign sw.o_min  = min_q;
  assign sw.o_hour = hour_q;
  assign sw.o_zero = zero_q;

endmodule

`default_nettype wire

// File: doc/stopwatch_dp.md
STOPWATCH_DP -- requirements
Module: stopwatch_dp

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 100, time-base rate in Hz; DIV = CLK_FREQ/TICK_HZ, integer, DIV >= 2.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_clear  input  1  level; zero all counters while high.
REQ-006 SHALL have port i_runstop  input  1  level; count up while high.
REQ-007 SHALL have port i_count_down  input  1  level; count down while high.
REQ-008 SHALL have port o_msec  output  7  hundredths of a second, 0..99.
REQ-009 SHALL have port o_sec  output  6  seconds, 0..59.
REQ-010 SHALL have port o_min  output  6  minutes, 0..59.
REQ-011 SHALL have port o_hour  output  5  hours, 0..23.
REQ-012 SHALL have port o_zero  output  1  one-cycle pulse when a count-down reaches 00:00:00.00.

Function
REQ-013 SHALL contain a tick divider counting 0..DIV-1; on the edge where the divider is DIV-1 and enabled, the divider returns to 0 and one tick is generated.
REQ-014 SHALL enable the divider only when the mode is UP or DOWN; in HOLD the divider keeps its value, so resuming continues the partial period.
REQ-015 SHALL decode the mode with priority i_clear > i_count_down > i_runstop: CLEAR, DOWN, UP; if none is high, the mode is HOLD.
REQ-016 SHALL, in CLEAR, set the divider and all time fields to 0 on every clock edge, with o_zero = 0.
REQ-017 SHALL, on an UP tick, increment the cascade msec 99->0 carry, sec 59->0 carry, min 59->0 carry, hour 23->0.
REQ-018 SHALL, on an UP tick at 23:59:59.99, wrap to 00:00:00.00 and leave o_zero low.
REQ-019 SHALL, on a DOWN tick, decrement with borrows: msec 0->99 borrow, sec 0->59 borrow, min 0->59 borrow, hour decrements.
REQ-020 SHALL, in DOWN with all fields 0, hold at zero, never wrap to 23:59:59.99, and keep the divider at 0.
REQ-021 SHALL pulse o_zero high for exactly one clk in the cycle after the edge on which a DOWN tick changes the value from 00:00:00.01 to 0.
REQ-022 SHALL NOT pulse o_zero again while the value stays at zero, nor on CLEAR or reset.
REQ-023 SHALL update the time fields on the same edge the tick is generated (zero added latency); the outputs are registered values.
REQ-024 SHALL update all fields atomically in one edge; intermediate carry or borrow states are never visible.
REQ-025 SHALL keep every field within its legal range under all input combinations.

Reset
REQ-026 SHALL, while rst = 1, force the divider, o_msec, o_sec, o_min and o_hour to 0 and o_zero to 0, independent of clk.
REQ-027 SHALL, after rst deasserts mid-count, restart from 00:00:00.00 with a fresh divider period; the first tick follows DIV enabled cycles.

Verification (CLK_FREQ=1000, TICK_HZ=100, DIV=10)
REQ-028 SHALL cover: rst released, i_runstop=1 for 10 clk -> o_msec=1 on the 10th edge; after 1000 enabled clk -> o_sec=1, o_msec=0.
REQ-029 SHALL cover: preload 23:59:59.99 by counting, i_runstop=1 for one tick -> 00:00:00.00 and o_zero stays 0.
REQ-030 SHALL cover: value 00:00:01.00, i_count_down=1 -> 00:00:00.99 after one tick; at zero, o_zero pulses once, the value holds and no further pulses occur over 50 more clk.
REQ-031 SHALL cover: i_runstop=1 for 5 clk, then low for 20 clk, then high again -> the first tick arrives after 5 more clk (divider preserved).
REQ-032 SHALL cover: i_clear=1 together with i_runstop=1 and i_count_down=1 -> all fields 0 and the divider at 0 on the next edge; clear wins.
REQ-033 SHALL cover: rst asserted asynchronously between clk edges at 00:01:23.45 -> outputs read 0 before the next clk edge.
